// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-detection inputs and pipeline-control outputs of the stall controller.
// The master side is the pipeline datapath; the slave side is hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_busy;
   logic              branch_taken;
   logic              halt;
   logic              st;
   logic              pc_we;
   logic              ifid_we;
   logic              ifid_flush;
   logic              pipe_hold;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             mem_busy, branch_taken, halt,
      input  st, pc_we, ifid_we, ifid_flush, pipe_hold, halted, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
             mem_busy, branch_taken, halt,
      output st, pc_we, ifid_we, ifid_flush, pipe_hold, halted, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use bubbles, memory-wait freeze, branch flush, halt,
// with a saturating count of cycles where the PC did not advance.
module hazard_stall_ctrl #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input logic               clk,
   input logic               rst_n,
   hazard_stall_ctrl_if.slave bus
);
   localparam int unsigned LatW = 3;
   localparam logic [LatW-1:0] LatInit = LatW'(LOAD_LAT - 1);

   typedef enum logic [1:0] {StRun, StLuStall, StHalted} state_e;

   state_e            state_q, state_d;
   logic [LatW-1:0]   lat_q, lat_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic              lu_hit;
   logic              st, pc_we, ifid_we, ifid_flush, pipe_hold, halted;
   logic              cnt_inc;

   assign rs1 = bus.id_rs1;
   assign rs2 = bus.id_rs2;
   assign rd  = bus.ex_rd;

   // x0 is hardwired, so a load targeting it never creates a dependency.
   assign lu_hit = bus.ex_mem_read && (rd != '0) &&
                   ((bus.id_use_rs1 && (rs1 == rd)) || (bus.id_use_rs2 && (rs2 == rd)));

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      st         = 1'b0;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      pipe_hold  = 1'b0;
      halted     = 1'b0;
      case (state_q)
         StHalted: begin
            st      = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            halted  = 1'b1;
         end
         default: begin
            if (bus.halt) begin
               st      = 1'b1;
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               state_d = StHalted;
            end else if (bus.mem_busy) begin
               pipe_hold = 1'b1;
               pc_we     = 1'b0;
               ifid_we   = 1'b0;
            end else if (bus.branch_taken) begin
               // Flushing IF/ID also squashes any instruction stalled in ID.
               ifid_flush = 1'b1;
               st         = 1'b1;
               lat_d      = '0;
               state_d    = StRun;
            end else if (state_q == StLuStall) begin
               st      = 1'b1;
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               lat_d   = lat_q - LatW'(1);
               if (lat_q == LatW'(1)) state_d = StRun;
            end else if (lu_hit) begin
               st      = 1'b1;
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               if (LOAD_LAT > 1) begin
                  lat_d   = LatInit;
                  state_d = StLuStall;
               end
            end
         end
      endcase
      // Outputs track reset immediately rather than waiting for a clock edge.
      if (!rst_n) begin
         st         = 1'b1;
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b0;
         pipe_hold  = 1'b0;
         halted     = 1'b0;
      end
   end

   assign cnt_inc = !pc_we && (state_q != StHalted) && !bus.halt && (cnt_q != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         lat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.st         = st;
   assign bus.pc_we      = pc_we;
   assign bus.ifid_we    = ifid_we;
   assign bus.ifid_flush = ifid_flush;
   assign bus.pipe_hold  = pipe_hold;
   assign bus.halted     = halted;
   assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Three controller variants (LOAD_LAT 1/3, narrow counter) driven in lockstep and
// compared each cycle against a remaining-bubble-count reference model.
module tb_hazard_stall_ctrl;
   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, mem_busy, branch_taken, halt;

   hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a ();
   hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_b ();
   hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(3))  if_c ();

   hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   assign if_a.id_rs1 = id_rs1;  assign if_b.id_rs1 = id_rs1;  assign if_c.id_rs1 = id_rs1;
   assign if_a.id_rs2 = id_rs2;  assign if_b.id_rs2 = id_rs2;  assign if_c.id_rs2 = id_rs2;
   assign if_a.ex_rd  = ex_rd;   assign if_b.ex_rd  = ex_rd;   assign if_c.ex_rd  = ex_rd;
   assign if_a.id_use_rs1 = id_use_rs1;
   assign if_b.id_use_rs1 = id_use_rs1;
   assign if_c.id_use_rs1 = id_use_rs1;
   assign if_a.id_use_rs2 = id_use_rs2;
   assign if_b.id_use_rs2 = id_use_rs2;
   assign if_c.id_use_rs2 = id_use_rs2;
   assign if_a.ex_mem_read = ex_mem_read;
   assign if_b.ex_mem_read = ex_mem_read;
   assign if_c.ex_mem_read = ex_mem_read;
   assign if_a.mem_busy = mem_busy;  assign if_b.mem_busy = mem_busy;
   assign if_c.mem_busy = mem_busy;
   assign if_a.branch_taken = branch_taken;
   assign if_b.branch_taken = branch_taken;
   assign if_c.branch_taken = branch_taken;
   assign if_a.halt = halt;  assign if_b.halt = halt;  assign if_c.halt = halt;

   // {st, pc_we, ifid_we, ifid_flush, pipe_hold, halted}
   logic [5:0]  obs  [3];
   logic [15:0] ocnt [3];
   assign obs[0] = {if_a.st, if_a.pc_we, if_a.ifid_we, if_a.ifid_flush, if_a.pipe_hold,
                    if_a.halted};
   assign obs[1] = {if_b.st, if_b.pc_we, if_b.ifid_we, if_b.ifid_flush, if_b.pipe_hold,
                    if_b.halted};
   assign obs[2] = {if_c.st, if_c.pc_we, if_c.ifid_we, if_c.ifid_flush, if_c.pipe_hold,
                    if_c.halted};
   assign ocnt[0] = if_a.stall_cnt;
   assign ocnt[1] = if_b.stall_cnt;
   assign ocnt[2] = {13'd0, if_c.stall_cnt};

   int n_eval = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: bubbles still owed, halted flag, stall count.
   int lat  [3] = '{1, 3, 3};
   int cmax [3] = '{65535, 65535, 7};
   int rem  [3];
   bit hlt  [3];
   int cnt  [3];

   localparam logic [5:0] OutReset  = 6'b100000;
   localparam logic [5:0] OutBubble = 6'b100000;
   localparam logic [5:0] OutHalted = 6'b100001;
   localparam logic [5:0] OutFreeze = 6'b000010;
   localparam logic [5:0] OutFlush  = 6'b111100;
   localparam logic [5:0] OutNormal = 6'b011000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         rem[k] = 0;
         hlt[k] = 1'b0;
         cnt[k] = 0;
      end
   endtask

   task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                         input bit mr, input int rd, input bit busy, input bit br,
                         input bit h);
      id_rs1 = 5'(rs1);  id_rs2 = 5'(rs2);  id_use_rs1 = u1;  id_use_rs2 = u2;
      ex_mem_read = mr;  ex_rd = 5'(rd);  mem_busy = busy;  branch_taken = br;  halt = h;
   endtask

   task automatic set_rand(input bit h);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, h);
   endtask

   // One clock: compare at the falling edge, then advance the model to the next cycle.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         bit         lu;
         logic [5:0] e;
         @(negedge clk);
         lu = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         for (int k = 0; k < 3; k++) begin
            bit nh;
            nh = hlt[k];
            if (hlt[k])            e = OutHalted;
            else if (halt)         begin e = OutBubble; nh = 1'b1; end
            else if (mem_busy)     e = OutFreeze;
            else if (branch_taken) begin e = OutFlush; rem[k] = 0; end
            else if (rem[k] > 0)   begin e = OutBubble; rem[k]--; end
            else if (lu)           begin e = OutBubble; rem[k] = lat[k] - 1; end
            else                   e = OutNormal;
            n_eval++;
            assert (obs[k] === e) else begin
               n_fail++;
               $error("FAIL ctrl[%0d] cyc %0d: got %b want %b", k, cyc, obs[k], e);
            end
            n_eval++;
            assert (ocnt[k] === 16'(cnt[k])) else begin
               n_fail++;
               $error("FAIL stall_cnt[%0d] cyc %0d: got %0d want %0d", k, cyc, ocnt[k],
                      cnt[k]);
            end
            if (!hlt[k] && !halt && !e[4] && cnt[k] < cmax[k]) cnt[k]++;
            hlt[k] = nh;
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   // Reset asserted away from any clock edge; outputs must respond without a clock.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_eval++;
         assert (obs[k] === OutReset) else begin
            n_fail++;
            $error("FAIL reset_out[%0d]: got %b want %b", k, obs[k], OutReset);
         end
         n_eval++;
         assert (ocnt[k] === 16'd0) else begin
            n_fail++;
            $error("FAIL reset_cnt[%0d]: got %0d want 0", k, ocnt[k]);
         end
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      async_reset();

      // Load-use hit for one cycle, then cleared.
      set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(4);
      // Load to x0 never stalls.
      set_in(0, 0, 1, 0, 1, 0, 0, 0, 0);  step(2);
      // Memory wait during the second bubble cycle.
      set_in(7, 7, 0, 1, 1, 7, 0, 0, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);  step(2);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(4);
      // Hazard and memory wait together: freeze first, hazard seen after.
      set_in(3, 0, 1, 0, 1, 3, 1, 0, 0);  step(2);
      set_in(3, 0, 1, 0, 1, 3, 0, 0, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(3);
      // Branch with a hazard in RUN, then a branch during LU_STALL.
      set_in(2, 2, 1, 1, 1, 2, 0, 1, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(2);
      set_in(2, 4, 0, 1, 1, 4, 0, 0, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(2);

      for (int i = 0; i < 400; i++) begin
         set_rand(1'b0);
         step(1);
      end

      // Halt is sticky: random traffic must not wake the core.
      set_in(1, 1, 1, 1, 1, 1, 0, 0, 1);  step(1);
      for (int i = 0; i < 12; i++) begin
         set_rand(1'($urandom_range(0, 1)));
         step(1);
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      async_reset();
      step(2);

      // Reset in the middle of a load-use stall.
      set_in(6, 0, 1, 0, 1, 6, 0, 0, 0);  step(1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);  step(1);
      async_reset();
      step(3);

      for (int i = 0; i < 300; i++) begin
         set_rand(1'b0);
         step(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencer for the 5-stage RISC core. It detects load-use hazards, multi-cycle data-memory waits, taken branches and halt, and from these drives the PC and IF/ID write enables, the IF/ID flush and the `st` bubble select consumed by the ID-stage control mux. It contains a small FSM, a load-latency down-counter and a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register-address width.
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
CNT_W, 16, stall performance-counter width.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_rs1  in  REG_AW  source register 1 of the instruction in ID.
id_rs2  in  REG_AW  source register 2 of the instruction in ID.
id_use_rs1  in  1  instruction in ID reads rs1.
id_use_rs2  in  1  instruction in ID reads rs2.
ex_mem_read  in  1  instruction in EX is a load.
ex_rd  in  REG_AW  destination register of the instruction in EX.
mem_busy  in  1  data memory not ready; the whole pipeline must hold.
branch_taken  in  1  branch/jump resolved taken in EX.
halt  in  1  halt instruction decoded; sticky until reset.
st  out  1  1 = ID control word forced to zero (bubble into ID/EX).
pc_we  out  1  PC write enable.
ifid_we  out  1  IF/ID register write enable.
ifid_flush  out  1  clear IF/ID to NOP.
pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
halted  out  1  core halted.
stall_cnt  out  CNT_W  cycles with pc_we=0 since reset, excluding HALTED; saturates at all-ones.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n=0: state=RUN, lat_cnt=0, stall_cnt=0, st=1, pc_we=0, ifid_we=0, ifid_flush=0, pipe_hold=0, halted=0. Reset asserted mid-stall aborts the stall immediately.
- Hazard term, combinational: lu_hit = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Outputs are Mealy: decoded from the current state and current inputs in the same cycle, with zero latency.
- Default output, "normal": st=0, pc_we=1, ifid_we=1, ifid_flush=0, pipe_hold=0, halted=0.
- Priority within a cycle: halt > mem_busy > branch_taken > lu_hit/LU_STALL > normal.
- States:
  - RUN:
    - halt=1 -> HALTED. This cycle: st=1, pc_we=0, ifid_we=0.
    - else mem_busy=1 -> freeze. pipe_hold=1, pc_we=0, ifid_we=0, st=0; stay in RUN.
    - else branch_taken=1 -> flush. ifid_flush=1, st=1, pc_we=1, ifid_we=1; stay in RUN.
    - else lu_hit=1 -> bubble. st=1, pc_we=0, ifid_we=0. If LOAD_LAT>1: lat_cnt<=LOAD_LAT-1 and go to LU_STALL; else stay in RUN.
    - else normal.
  - LU_STALL:
    - halt -> HALTED, outputs as in RUN.
    - mem_busy -> freeze outputs; lat_cnt holds.
    - branch_taken -> flush outputs, lat_cnt<=0, go to RUN (the stalled ID instruction is squashed).
    - otherwise: st=1, pc_we=0, ifid_we=0 regardless of lu_hit; lat_cnt decrements; when lat_cnt==1, return to RUN next cycle.
  - HALTED: st=1, pc_we=0, ifid_we=0, halted=1, pipe_hold=0; exit only via reset.
- stall_cnt: increments on each clock where pc_we=0 and state!=HALTED and the halt input=0; holds at 2^CNT_W-1.
- ex_rd==0 never causes a stall (x0 hardwired).
- Simultaneous lu_hit and mem_busy: freeze only; the hazard is re-evaluated once mem_busy drops.

Test Plan:
1. Load-use, LOAD_LAT=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> that cycle st=1, pc_we=0, ifid_we=0; next cycle with the hazard cleared, normal; stall_cnt=1.
2. LOAD_LAT=3, same hit for 1 cycle then cleared -> st=1 and pc_we=0 for exactly 3 consecutive cycles, then normal; stall_cnt=3.
3. ex_rd=0 with id_rs1=0, id_use_rs1=1, ex_mem_read=1 -> no stall; st=0, pc_we=1.
4. LOAD_LAT=3 with mem_busy=1 for 2 cycles during the 2nd stall cycle -> pipe_hold=1 for those 2 cycles, lat_cnt frozen, total st=1 cycles still 3; stall_cnt=5.
5. branch_taken=1 together with lu_hit in RUN -> ifid_flush=1, st=1, pc_we=1, no LU_STALL entry; branch_taken during LU_STALL -> immediate return to RUN.
6. halt=1 -> halted=1, pc_we=0 held for 10+ cycles, stall_cnt frozen; assert rst_n=0 mid-LU_STALL -> outputs go to reset values asynchronously, stall_cnt=0.
